// File: rtl/lh_msg_framer_if.sv
// Byte-stream and light-hash command bundle for lh_msg_framer.
// The master side is the environment (upstream source plus hash); the slave side is the framer.
interface lh_msg_framer_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        hash_busy;
    logic        digest_ready;
    logic [7:0]  message_byte;
    logic        message_valid;
    logic [1:0]  state;
    logic        frame_done;
    logic [15:0] byte_count;

    modport master (
        output in_byte, in_valid, in_last, hash_busy, digest_ready,
        input  in_ready, message_byte, message_valid, state, frame_done, byte_count
    );

    modport slave (
        input  in_byte, in_valid, in_last, hash_busy, digest_ready,
        output in_ready, message_byte, message_valid, state, frame_done, byte_count
    );
endinterface

// File: rtl/lh_msg_framer.sv
// Frames a byte stream into head/message/tail command strobes for the light hash.
// Define LH_FRAMER_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise a single holding register.
module lh_msg_framer #(
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    lh_msg_framer_if.slave bus
);

`ifdef LH_FRAMER_FIFO_EN
    localparam int DEPTH = FIFO_DEPTH;
`else
    localparam int DEPTH = 1;
`endif
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, HEAD, HGAP, FETCH, MSG, MGAP, TAIL, TWAIT} fsm_t;

    fsm_t          st, nxt;
    logic [CW-1:0] count, count_nxt;
    logic          push, pop;
    logic [7:0]    head_byte;
    logic          head_last;
    logic          last_flag;
    logic [1:0]    code_nxt;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (st == FETCH) && (count != '0);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // in_ready is computed from the post-edge occupancy, so a pop while full never admits a push that same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            bus.in_ready <= 1'b0;
        end else begin
            count        <= count_nxt;
            bus.in_ready <= (count_nxt != FULL);
        end
    end

`ifdef LH_FRAMER_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.in_last, bus.in_byte};
    end

    assign {head_last, head_byte} = mem[rd_ptr];
`else
    logic [8:0] hold;

    always_ff @(posedge clk) begin
        if (push) hold <= {bus.in_last, bus.in_byte};
    end

    assign {head_last, head_byte} = hold;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end

    always_comb begin
        nxt      = st;
        code_nxt = bus.state;
        case (st)
            IDLE:    if (count != '0) nxt = HEAD;
            HEAD:    nxt = HGAP;
            HGAP:    nxt = FETCH;
            FETCH:   if (count != '0) nxt = MSG;
            MSG:     nxt = MGAP;
            MGAP:    if (!bus.hash_busy) nxt = last_flag ? TAIL : FETCH;
            TAIL:    nxt = TWAIT;
            TWAIT:   if (bus.digest_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // Gap and wait states keep the code of the last command issued
        case (nxt)
            IDLE:    code_nxt = 2'b11;
            HEAD:    code_nxt = 2'b00;
            MSG:     code_nxt = 2'b10;
            TAIL:    code_nxt = 2'b01;
            default: code_nxt = bus.state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.message_valid <= 1'b0;
            bus.state         <= 2'b11;
            bus.message_byte  <= 8'h00;
            bus.frame_done    <= 1'b0;
            bus.byte_count    <= 16'h0000;
            last_flag         <= 1'b0;
        end else begin
            bus.message_valid <= (nxt == HEAD) || (nxt == MSG) || (nxt == TAIL);
            bus.state         <= code_nxt;
            bus.frame_done    <= (st == TWAIT) && bus.digest_ready;
            if (pop) begin
                bus.message_byte <= head_byte;
                last_flag        <= head_last;
            end
            if (st == HEAD)
                bus.byte_count <= 16'h0000;
            else if (st == MSG && bus.byte_count != 16'hFFFF)
                bus.byte_count <= bus.byte_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_lh_msg_framer.sv
// Randomized bench for lh_msg_framer: a queue model of the expected strobe stream per frame
// is compared against a monitor log of head/message/tail strobes and frame_done pulses.
module tb_lh_msg_framer;

    localparam int FIFO_DEPTH = 4;
`ifdef LH_FRAMER_FIFO_EN
    localparam int EFF_DEPTH = FIFO_DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif
    localparam int C_HEAD = 0;
    localparam int C_TAIL = 1;
    localparam int C_MSG  = 2;
    localparam int C_DONE = 4;

    typedef int int_q_t[$];

    logic clk;
    logic rst;

    lh_msg_framer_if bus ();

    lh_msg_framer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     checks;
    int     errors;
    int_q_t log_code, log_byte, exp_code, exp_byte;
    int     fd_count;
    int     msg_count;
    bit     hold_busy, hold_dig_low, abort_send;
    logic   prev_mv;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Hash side: random busy/digest handshakes unless held by a test
    initial begin
        bus.hash_busy    = 1'b0;
        bus.digest_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.hash_busy    = hold_busy    ? 1'b1 : ($urandom_range(0, 2) == 0);
            bus.digest_ready = hold_dig_low ? 1'b0 : ($urandom_range(0, 3) == 0);
        end
    end

    // Strobe monitor: logs every command strobe and frame_done pulse in order
    initial begin
        prev_mv = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.message_valid === 1'b1) begin
                checks++;
                if (prev_mv === 1'b1) begin
                    errors++;
                    $display("FAIL valid_gap: message_valid high on consecutive cycles at %0t, required a low cycle between", $time);
                end
                log_code.push_back(int'(bus.state));
                log_byte.push_back(bus.state == 2'b10 ? int'(bus.message_byte) : 0);
                if (bus.state == 2'b10) msg_count++;
            end
            if (bus.frame_done === 1'b1) begin
                fd_count++;
                log_code.push_back(C_DONE);
                log_byte.push_back(0);
            end
            prev_mv = bus.message_valid;
        end
    end

    function automatic int_q_t str_to_q(input string s);
        int_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(int'(s[i]));
        return q;
    endfunction

    function automatic int_q_t rand_frame(input int len);
        int_q_t q;
        for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 255)));
        return q;
    endfunction

    // Reference: a frame is head, one message per byte in order, tail, then frame_done
    task automatic add_expect(input int_q_t f);
        exp_code.push_back(C_HEAD); exp_byte.push_back(0);
        foreach (f[i]) begin
            exp_code.push_back(C_MSG); exp_byte.push_back(f[i]);
        end
        exp_code.push_back(C_TAIL); exp_byte.push_back(0);
        exp_code.push_back(C_DONE); exp_byte.push_back(0);
    endtask

    task automatic clear_logs();
        log_code.delete(); log_byte.delete();
        exp_code.delete(); exp_byte.delete();
        fd_count  = 0;
        msg_count = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int budget);
        logic acc;
        bit   done;
        done = 1'b0;
        bus.in_byte  = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc || abort_send) begin
                done = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom_range(0, 1));
        bus.in_byte  = 8'($urandom_range(0, 255));
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: byte %02h not accepted within %0d cycles", b, budget);
        end
    endtask

    task automatic send_frame(input int_q_t f, input bit gaps);
        foreach (f[i]) begin
            if (abort_send) break;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_byte(8'(f[i]), (i == f.size() - 1), 400);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int c = 0; c < budget && fd_count < target; c++) @(negedge clk);
        if (fd_count < target) begin
            checks++; errors++;
            $display("FAIL done_timeout: frame_done count %0d, required %0d", fd_count, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); end
        checks++; if (bus.message_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", bus.message_valid); end
        checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL rst_state: got %b, required 11", bus.state); end
        checks++; if (bus.message_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %02h, required 00", bus.message_byte); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", bus.frame_done); end
        checks++; if (bus.byte_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %0d, required 0", bus.byte_count); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, required 1", bus.in_ready); end
    endtask

    task automatic test_single_byte();
        int_q_t f;
        clear_logs();
        hold_dig_low = 1'b1;
        f = '{8'h41};
        add_expect(f);
        send_byte(8'h41, 1'b1, 50);
        checks++; if (bus.message_valid !== 1'b0) begin errors++; $display("FAIL head_early: valid %b one edge after accept, required 0", bus.message_valid); end
        @(posedge clk); #1;
        checks++; if (bus.message_valid !== 1'b1 || bus.state !== 2'b00) begin
            errors++; $display("FAIL head_timing: valid %b state %b, required valid 1 state 00", bus.message_valid, bus.state);
        end
        for (int c = 0; c < 300 && log_code.size() < 3; c++) @(negedge clk);
        repeat (40) @(negedge clk);
        checks++; if (fd_count !== 0 || bus.state !== 2'b01) begin
            errors++; $display("FAIL stuck_digest: frame_done count %0d state %b, required 0 and 01", fd_count, bus.state);
        end
        hold_dig_low = 1'b0;
        wait_done(1, 300);
        checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL idle_code: got %b, required 11", bus.state); end
        checks++; if (bus.byte_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d, required 1", bus.byte_count); end
        checks++;
        if (log_code.size() != exp_code.size()) begin
            errors++; $display("FAIL single_len: log has %0d entries, required %0d", log_code.size(), exp_code.size());
        end else foreach (exp_code[i]) begin
            checks++;
            if (log_code[i] !== exp_code[i] || log_byte[i] !== exp_byte[i]) begin
                errors++; $display("FAIL single_seq[%0d]: got code %0d byte %02h, required code %0d byte %02h", i, log_code[i], log_byte[i], exp_code[i], exp_byte[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_frames();
        int_q_t f;
        int     last_len;
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            last_len = $urandom_range(1, 20);
            f = rand_frame(last_len);
            add_expect(f);
            send_frame(f, (k % 2) == 1);
        end
        wait_done(4, 4000);
        checks++; if (bus.byte_count !== 16'(last_len)) begin errors++; $display("FAIL rand_count: got %0d, required %0d", bus.byte_count, last_len); end
        checks++;
        if (log_code.size() != exp_code.size()) begin
            errors++; $display("FAIL rand_len: log has %0d entries, required %0d", log_code.size(), exp_code.size());
        end else foreach (exp_code[i]) begin
            checks++;
            if (log_code[i] !== exp_code[i] || log_byte[i] !== exp_byte[i]) begin
                errors++; $display("FAIL rand_seq[%0d]: got code %0d byte %02h, required code %0d byte %02h", i, log_code[i], log_byte[i], exp_code[i], exp_byte[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        string names[3];
        clear_logs();
        names[0] = "H4rdw4r3_Tr0j4n";
        names[1] = "AlessandroAndGiacomo";
        names[2] = "AlessandroandGiacomo";
        foreach (names[k]) begin
            add_expect(str_to_q(names[k]));
            send_frame(str_to_q(names[k]), 1'b0);
        end
        wait_done(3, 4000);
        checks++; if (bus.byte_count !== 16'd20) begin errors++; $display("FAIL b2b_count: got %0d, required 20", bus.byte_count); end
        checks++;
        if (log_code.size() != exp_code.size()) begin
            errors++; $display("FAIL b2b_len: log has %0d entries, required %0d", log_code.size(), exp_code.size());
        end else foreach (exp_code[i]) begin
            checks++;
            if (log_code[i] !== exp_code[i] || log_byte[i] !== exp_byte[i]) begin
                errors++; $display("FAIL b2b_seq[%0d]: got code %0d byte %02h, required code %0d byte %02h", i, log_code[i], log_byte[i], exp_code[i], exp_byte[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int_q_t f;
        int     idx;
        int     exp_acc;
        logic   acc;
        clear_logs();
        hold_busy = 1'b1;
        f = rand_frame(6);
        add_expect(f);
        exp_acc = (EFF_DEPTH + 1 < 6) ? EFF_DEPTH + 1 : 6;
        idx = 0;
        for (int c = 0; c < 16; c++) begin
            bus.in_valid = (idx < 6);
            bus.in_byte  = 8'(f[idx < 6 ? idx : 5]);
            bus.in_last  = (idx == 5);
            @(negedge clk); acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        checks++; if (idx !== exp_acc) begin errors++; $display("FAIL bp_accepted: %0d bytes accepted, required %0d", idx, exp_acc); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b, required 0 while full", bus.in_ready); end
        hold_busy = 1'b0;
        for (int i = idx; i < 6; i++) send_byte(8'(f[i]), (i == 5), 400);
        wait_done(1, 1000);
        checks++; if (bus.byte_count !== 16'd6) begin errors++; $display("FAIL bp_count: got %0d, required 6", bus.byte_count); end
        checks++;
        if (log_code.size() != exp_code.size()) begin
            errors++; $display("FAIL bp_len: log has %0d entries, required %0d", log_code.size(), exp_code.size());
        end else foreach (exp_code[i]) begin
            checks++;
            if (log_code[i] !== exp_code[i] || log_byte[i] !== exp_byte[i]) begin
                errors++; $display("FAIL bp_seq[%0d]: got code %0d byte %02h, required code %0d byte %02h", i, log_code[i], log_byte[i], exp_code[i], exp_byte[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        clear_logs();
        fork
            send_frame(str_to_q("ABCDEFGH"), 1'b0);
            begin
                for (int c = 0; c < 1000 && msg_count < 3; c++) @(negedge clk);
                if (msg_count < 3) begin
                    checks++; errors++;
                    $display("FAIL mr_wait: %0d message strobes seen, required 3", msg_count);
                end
                rst = 1'b1;
                abort_send = 1'b1;
            end
        join
        #1;
        checks++; if (bus.message_valid !== 1'b0 || bus.state !== 2'b11 || bus.message_byte !== 8'h00) begin
            errors++; $display("FAIL mr_outputs: valid %b state %b byte %02h, required 0 11 00", bus.message_valid, bus.state, bus.message_byte);
        end
        checks++; if (bus.in_ready !== 1'b0 || bus.frame_done !== 1'b0 || bus.byte_count !== 16'h0) begin
            errors++; $display("FAIL mr_ctrl: ready %b done %b count %0d, required 0 0 0", bus.in_ready, bus.frame_done, bus.byte_count);
        end
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        abort_send = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b, required 1 after reset release", bus.in_ready); end
        repeat (30) @(negedge clk);
        checks++; if (log_code.size() !== 0) begin errors++; $display("FAIL mr_no_tail: %0d strobes after reset, required 0", log_code.size()); end
        @(posedge clk); #1;
        add_expect(str_to_q("3.14"));
        send_frame(str_to_q("3.14"), 1'b1);
        wait_done(1, 1000);
        checks++; if (bus.byte_count !== 16'd4) begin errors++; $display("FAIL mr_count: got %0d, required 4", bus.byte_count); end
        checks++;
        if (log_code.size() != exp_code.size()) begin
            errors++; $display("FAIL mr_len: log has %0d entries, required %0d", log_code.size(), exp_code.size());
        end else foreach (exp_code[i]) begin
            checks++;
            if (log_code[i] !== exp_code[i] || log_byte[i] !== exp_byte[i]) begin
                errors++; $display("FAIL mr_seq[%0d]: got code %0d byte %02h, required code %0d byte %02h", i, log_code[i], log_byte[i], exp_code[i], exp_byte[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        hold_busy    = 1'b0;
        hold_dig_low = 1'b0;
        abort_send   = 1'b0;
        rst          = 1'b1;
        test_reset();
        test_single_byte();
        test_random_frames();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
